// File: rtl/f19_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : f19_pkg
//  Description : Shared constants, state encoding and helpers for the
//                float19 interpolator timing controller and its fixed->float
//                converters. float19 = sign[18] | exp[17:10] (bias 127) |
//                mant[9:0].
//  Revision    : 1.0 - initial release
// ============================================================================
package f19_pkg;

  localparam int EXP_W      = 8;
  localparam int MAN_W      = 10;
  localparam int EXP_BIAS   = 127;
  localparam int DATA_WIDTH = 1 + EXP_W + MAN_W;

  // Fractional bits of the NCO accumulator and of the step input.
  localparam int PHASE_W    = 16;

  // Taps in the interpolator delay line that must be primed before output.
  localparam int FILL_DEPTH = 4;

  localparam logic [PHASE_W:0] STEP_ONE = 17'h10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOAD = 2'd3
  } nco_state_e;

  // Steps above 1.0 would skip input samples; saturate them to exactly 1.0.
  function automatic logic [PHASE_W:0] clamp_step(input logic [PHASE_W:0] step);
    return (step > STEP_ONE) ? STEP_ONE : step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_to_f19.sv
`default_nettype none
// ============================================================================
//  Module      : phase_to_f19
//  Description : Combinational unsigned fraction -> float19 converter.
//                Leading-one detect, normalize, optional rounding.
//                A zero fraction maps to +0 (all bits zero); otherwise
//                exp = EXP_BIAS - FRAC_W + p, where p is the leading-one index.
//  Config      : INTERP_NCO_CTRL_ROUND_EN - defined: round-to-nearest-even on
//                the discarded bits (mantissa overflow bumps the exponent);
//                undefined: mantissa is truncated.
//  Ports       : frac [FRAC_W-1:0]     in   unsigned fraction (0.frac)
//                f19  [DATA_WIDTH-1:0] out  float19 result
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_to_f19
  import f19_pkg::*;
#(
  parameter int FRAC_W = PHASE_W
) (
  input  logic [FRAC_W-1:0]     frac,
  output logic [DATA_WIDTH-1:0] f19
);

  localparam int IDX_W  = $clog2(FRAC_W);
  // Bits below the mantissa after normalization (leading one sits at MSB).
  localparam int DROP_W = FRAC_W - 1 - MAN_W;
  localparam logic [EXP_W-1:0] EXP_OFS = EXP_W'(EXP_BIAS - FRAC_W);

  logic [IDX_W-1:0]  lead_idx;
  logic [IDX_W-1:0]  shamt;
  logic [FRAC_W-1:0] norm;
  logic [MAN_W-1:0]  mant_trunc;
  logic [EXP_W-1:0]  exp_base;
  logic [MAN_W-1:0]  mant_fin;
  logic [EXP_W-1:0]  exp_fin;
  logic              unused_norm;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (frac[i]) begin
        lead_idx = IDX_W'(i);
      end
    end
  end

  assign shamt      = IDX_W'(FRAC_W - 1) - lead_idx;
  assign norm       = frac << shamt;
  assign mant_trunc = norm[FRAC_W-2 -: MAN_W];
  assign exp_base   = EXP_OFS + EXP_W'(lead_idx);

`ifdef INTERP_NCO_CTRL_ROUND_EN
  logic           guard_bit;
  logic           sticky_bit;
  logic           round_up;
  logic [MAN_W:0] mant_sum;

  assign guard_bit  = norm[DROP_W-1];
  assign sticky_bit = |norm[DROP_W-2:0];
  // Ties (guard set, nothing below) round toward an even mantissa.
  assign round_up   = guard_bit & (sticky_bit | mant_trunc[0]);
  assign mant_sum   = {1'b0, mant_trunc} + {{MAN_W{1'b0}}, round_up};
  // On mantissa overflow the low bits are already zero; only exp moves.
  assign mant_fin   = mant_sum[MAN_W-1:0];
  assign exp_fin    = exp_base + {{(EXP_W-1){1'b0}}, mant_sum[MAN_W]};
  // The leading one is implicit in the float format.
  assign unused_norm = norm[FRAC_W-1];
`else
  assign mant_fin    = mant_trunc;
  assign exp_fin     = exp_base;
  assign unused_norm = ^{norm[FRAC_W-1], norm[DROP_W-1:0]};
`endif

  assign f19 = (frac == '0) ? '0 : {1'b0, exp_fin, mant_fin};

endmodule
`default_nettype wire

// File: rtl/interp_nco_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : interp_nco_ctrl
//  Description : Fractional-rate timing controller for the float19 Farrow
//                interpolator. Primes the 4-tap delay line, then runs a
//                PHASE_W-bit NCO: every RUN cycle emits one output (mu),
//                every accumulator carry loads one new input sample.
//                All outputs are registered and reflect the decisions of the
//                previous cycle; in_ready is a pure state decode.
//  Config      : INTERP_NCO_CTRL_ROUND_EN - round mu mantissa to nearest
//                even instead of truncating (see phase_to_f19).
//  Ports       : clk        in   clock, posedge
//                rst_n      in   async active-low reset
//                en         in   run enable, low forces IDLE
//                step       in   phase increment, 0x10000 = 1.0 (clamped)
//                in_valid   in   upstream sample valid
//                in_data    in   upstream float19 sample
//                in_ready   out  sample accepted this cycle when valid
//                x_load     out  strobe: interpolator shifts in x_data
//                x_data     out  sample for the delay line
//                mu_out     out  float19 fractional phase, held between pulses
//                out_valid  out  strobe: one output sample, mu_out valid
//                underrun   out  sticky: upstream starved a LOAD cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module interp_nco_ctrl
  import f19_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [PHASE_W:0]      step,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  x_load,
  output logic [DATA_WIDTH-1:0] x_data,
  output logic [DATA_WIDTH-1:0] mu_out,
  output logic                  out_valid,
  output logic                  underrun
);

  localparam int FILL_CNT_W = $clog2(FILL_DEPTH);
  localparam logic [FILL_CNT_W-1:0] FILL_LAST = FILL_CNT_W'(FILL_DEPTH - 1);

  nco_state_e              state_q,     state_d;
  logic [PHASE_W-1:0]      phase_q,     phase_d;
  logic [PHASE_W:0]        step_act_q,  step_act_d;
  logic [FILL_CNT_W-1:0]   fill_cnt_q,  fill_cnt_d;
  logic                    in_ready_q,  in_ready_d;
  logic                    x_load_q,    x_load_d;
  logic [DATA_WIDTH-1:0]   x_data_q,    x_data_d;
  logic [DATA_WIDTH-1:0]   mu_out_q,    mu_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    underrun_q,  underrun_d;

  logic [PHASE_W:0]        phase_sum;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   mu_f19;

  phase_to_f19 #(
    .FRAC_W (PHASE_W)
  ) u_phase_to_f19 (
    .frac (phase_q),
    .f19  (mu_f19)
  );

  // in_ready_q mirrors the state register, so accept never depends on a
  // combinational path through this block.
  assign accept    = in_valid & in_ready_q;
  // Top bit of the sum is the carry that schedules a sample load.
  assign phase_sum = {1'b0, phase_q} + step_act_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    step_act_d  = step_act_q;
    fill_cnt_d  = fill_cnt_q;
    x_load_d    = 1'b0;
    x_data_d    = x_data_q;
    mu_out_d    = mu_out_q;
    out_valid_d = 1'b0;
    underrun_d  = underrun_q;

    if (!en) begin
      // A handshake completing in this cycle is dropped on purpose: the
      // delay line is refilled from scratch on the next enable.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          phase_d    = '0;
          fill_cnt_d = '0;
          step_act_d = clamp_step(step);
          underrun_d = 1'b0;
          state_d    = ST_FILL;
        end

        ST_FILL: begin
          if (accept) begin
            x_load_d = 1'b1;
            x_data_d = in_data;
            if (fill_cnt_q == FILL_LAST) begin
              fill_cnt_d = '0;
              state_d    = ST_RUN;
            end else begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end
          end
        end

        ST_RUN: begin
          out_valid_d = 1'b1;
          mu_out_d    = mu_f19;
          phase_d     = phase_sum[PHASE_W-1:0];
          if (phase_sum[PHASE_W]) begin
            // Only a carry boundary may pick up a new step value.
            step_act_d = clamp_step(step);
            state_d    = ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (accept) begin
            x_load_d = 1'b1;
            x_data_d = in_data;
            state_d  = ST_RUN;
          end else begin
            underrun_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    in_ready_d = (state_d == ST_FILL) || (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      step_act_q  <= '0;
      fill_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      x_load_q    <= 1'b0;
      x_data_q    <= '0;
      mu_out_q    <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      step_act_q  <= step_act_d;
      fill_cnt_q  <= fill_cnt_d;
      in_ready_q  <= in_ready_d;
      x_load_q    <= x_load_d;
      x_data_q    <= x_data_d;
      mu_out_q    <= mu_out_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign x_load    = x_load_q;
  assign x_data    = x_data_q;
  assign mu_out    = mu_out_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_interp_nco_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interp_nco_ctrl
//  Description : Self-checking bench for interp_nco_ctrl. A stream model
//                predicts the ordered sequence of delay-line loads and mu
//                outputs from the NCO rules; the DUT's strobes are matched
//                against it, plus handshake, underrun and reset checks.
//  Config      : INTERP_NCO_CTRL_ROUND_EN selects the rounding reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interp_nco_ctrl;

  localparam int DW      = 19;
  localparam int PW      = 16;
  localparam int SRC_N   = 4096;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          en       = 1'b0;
  logic [PW:0]   step     = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready;
  logic          x_load;
  logic [DW-1:0] x_data;
  logic [DW-1:0] mu_out;
  logic          out_valid;
  logic          underrun;

  always #5 clk = ~clk;

  interp_nco_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .step      (step),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .x_load    (x_load),
    .x_data    (x_data),
    .mu_out    (mu_out),
    .out_valid (out_valid),
    .underrun  (underrun)
  );

  typedef struct {
    bit          is_load;
    logic [31:0] val;
    bit          carry;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] src[SRC_N];
  int            src_idx      = 0;
  int            n_tests      = 0;
  int            n_fail       = 0;
  int            en_age       = 0;
  int            off_age      = 0;
  int            vmode        = 0;
  int            stall_cnt    = 0;
  int            consumed     = 0;
  bit            started      = 1'b0;
  bit            exp_underrun = 1'b0;
  bit            en_req       = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference float19 of a 16-bit fraction, straight from the number format.
  function automatic logic [31:0] ref_f19(input int unsigned f);
    int unsigned p, q, r, e;
    if (f == 0) return 32'd0;
    p = 0;
    while ((f >> (p + 1)) != 0) p++;
    q = (f << 10) >> p;          // 1.mant scaled by 1024
    r = (f << 10) - (q << p);    // discarded remainder
    e = 111 + p;
`ifdef INTERP_NCO_CTRL_ROUND_EN
    if (p > 0) begin
      if (r > (32'd1 << (p - 1)) || (r == (32'd1 << (p - 1)) && q[0])) q++;
    end
    if (q == 2048) begin
      q = 1024;
      e++;
    end
`else
    if (r > 0) q = q;            // truncation keeps q
`endif
    return (e << 10) | (q - 1024);
  endfunction

  // Expected event stream for one enable period: fill, then phase stepping.
  task automatic build_model(input logic [PW:0] stp, input int nev);
    int unsigned c, ph, s;
    int di;
    c  = (stp > 17'h10000) ? 32'h10000 : {15'd0, stp};
    ph = 0;
    di = src_idx;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{1'b1, {13'd0, src[di]}, 1'b0});
      di = (di + 1) % SRC_N;
    end
    while (exp_q.size() < nev) begin
      exp_q.push_back('{1'b0, ref_f19(ph), 1'b0});
      s  = ph + c;
      ph = s % 65536;
      if (s >= 65536) begin
        exp_q.push_back('{1'b1, {13'd0, src[di]}, 1'b1});
        di = (di + 1) % SRC_N;
      end
    end
  endtask

  task automatic consume(input bit is_load, input logic [31:0] val, input string tag);
    ev_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.is_load = ~is_load;
      e.val     = 32'hdead_beef;
      e.carry   = 1'b0;
    end
    check_eq({tag, "_kind"}, {31'd0, is_load}, {31'd0, e.is_load});
    check_eq(tag, val, e.val);
    consumed++;
  endtask

  // One clock: observe registered outputs at negedge, then drive inputs.
  task automatic cycle();
    bit in_load;
    @(negedge clk);
    if (en) en_age++;  else en_age = 0;
    if (!en) off_age++; else off_age = 0;
    if (en_age == 1) check_eq("en_to_ready", {31'd0, in_ready}, 32'd1);
    if (off_age == 1) begin
      check_eq("off_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("off_x_load",    {31'd0, x_load},    32'd0);
      check_eq("off_in_ready",  {31'd0, in_ready},  32'd0);
    end
    if (en && vmode == 0 && started)
      check_eq("one_event", {31'd0, out_valid} + {31'd0, x_load}, 32'd1);
    if (out_valid) consume(1'b0, {13'd0, mu_out}, "mu");
    if (x_load) begin
      consume(1'b1, {13'd0, x_data}, "xdata");
      started = 1'b1;
    end
    check_eq("underrun", {31'd0, underrun}, {31'd0, exp_underrun});

    en      = en_req;
    in_load = en && exp_q.size() > 0 && exp_q[0].is_load && exp_q[0].carry;
    case (vmode)
      0: in_valid = 1'b1;
      1: in_valid = ($urandom_range(0, 3) != 0);
      default: begin
        if (in_load && stall_cnt < 3) begin
          in_valid = 1'b0;
          stall_cnt++;
        end else begin
          in_valid = 1'b1;
          if (!in_load) stall_cnt = 0;
        end
      end
    endcase
    in_data = src[src_idx];
    if (in_valid && in_ready) src_idx = (src_idx + 1) % SRC_N;
    if (en && en_age == 0)          exp_underrun = 1'b0;
    else if (in_load && !in_valid)  exp_underrun = 1'b1;
    if (!en) exp_q.delete();
  endtask

  task automatic run_segment(input logic [PW:0] stp, input int mode, input int target);
    int cyc;
    cyc       = 0;
    step      = stp;
    vmode     = mode;
    started   = 1'b0;
    consumed  = 0;
    stall_cnt = 0;
    build_model(stp, target + 24);
    en_req = 1'b1;
    while (consumed < target && cyc < 2000) begin
      cycle();
      cyc++;
    end
    check_eq("seg_progress", {31'd0, consumed >= target}, 32'd1);
    en_req = 1'b0;
    repeat (4) cycle();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          md;
    for (int i = 0; i < SRC_N; i++) begin
      r      = $urandom;
      src[i] = r[DW-1:0];
    end

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check_eq("rst_x_load",    {31'd0, x_load},    32'd0);
    check_eq("rst_x_data",    {13'd0, x_data},    32'd0);
    check_eq("rst_mu_out",    {13'd0, mu_out},    32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_underrun",  {31'd0, underrun},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    run_segment(17'h04000, 0, 30);
    run_segment(17'h10000, 0, 30);
    run_segment(17'h1C71C, 0, 30);
    run_segment(17'h0FFFF, 0, 30);
    run_segment(17'h00000, 1, 30);
    run_segment(17'h04000, 2, 40);
    run_segment(17'h02A00, 1, 40);
    for (int s = 0; s < 6; s++) begin
      r  = $urandom_range(0, 32'h1FFFF);
      md = $urandom_range(0, 2);
      run_segment(r[PW:0], md, 30);
    end

    // Asynchronous reset while running, then a full refill with en held high.
    step      = 17'h04000;
    vmode     = 0;
    started   = 1'b0;
    consumed  = 0;
    stall_cnt = 0;
    build_model(step, 40);
    en_req = 1'b1;
    for (int k = 0; k < 200 && consumed < 8; k++) cycle();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_in_ready",  {31'd0, in_ready},  32'd0);
    check_eq("arst_x_load",    {31'd0, x_load},    32'd0);
    check_eq("arst_x_data",    {13'd0, x_data},    32'd0);
    check_eq("arst_mu_out",    {13'd0, mu_out},    32'd0);
    check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_underrun",  {31'd0, underrun},  32'd0);
    exp_underrun = 1'b0;
    started      = 1'b0;
    consumed     = 0;
    build_model(step, 40);
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 200 && consumed < 20; k++) cycle();
    check_eq("arst_refill_progress", {31'd0, consumed >= 20}, 32'd1);
    en_req = 1'b0;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
